// File: rtl/tenv_clkgen_div_if.sv
// Control and status bundle for tenv_clkgen_div: per-channel programming
// inputs and the generated clock/status outputs, packed per channel.
interface tenv_clkgen_div_if #(
   parameter int CHANNELS = 2,
   parameter int CNT_W    = 16,
   parameter int BURST_W  = 8
);
   logic [CHANNELS-1:0]         init;
   logic [CHANNELS-1:0]         en;
   logic [CHANNELS*CNT_W-1:0]   time_high;
   logic [CHANNELS*CNT_W-1:0]   time_low;
   logic [CHANNELS*BURST_W-1:0] burst_len;
   logic [CHANNELS-1:0]         clocks;
   logic [CHANNELS-1:0]         busy;
   logic [CHANNELS-1:0]         done;
   logic [CHANNELS-1:0]         err;

   modport master (
      output init, en, time_high, time_low, burst_len,
      input  clocks, busy, done, err
   );

   modport slave (
      input  init, en, time_high, time_low, burst_len,
      output clocks, busy, done, err
   );
endinterface

// File: rtl/tenv_clkgen_div.sv
// Multi-channel clock/strobe generator: each channel produces a clock with
// programmable high/low phase lengths, glitch-free stop and optional bursts.
module tenv_clkgen_div #(
   parameter int CHANNELS = 2,
   parameter int CNT_W    = 16,
   parameter int BURST_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   tenv_clkgen_div_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2,
      HOLD = 2'd3
   } state_t;

   logic [CHANNELS-1:0] clocks_v;
   logic [CHANNELS-1:0] busy_v;
   logic [CHANNELS-1:0] done_v;
   logic [CHANNELS-1:0] err_v;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_t             state;
      state_t             state_nxt;
      logic [CNT_W-1:0]   cnt;
      logic [CNT_W-1:0]   cnt_nxt;
      logic [BURST_W-1:0] pcnt;
      logic [BURST_W-1:0] pcnt_nxt;
      logic               lvl;
      logic               lvl_nxt;
      logic               outq;
      logic               out_nxt;
      logic               err_q;
      logic               err_nxt;
      logic               done_q;
      logic               done_nxt;
      logic               busy_q;

      logic               en_i;
      logic               init_i;
      logic [CNT_W-1:0]   th;
      logic [CNT_W-1:0]   tl;
      logic [BURST_W-1:0] blen;
      logic [CNT_W-1:0]   tstart;
      logic [CNT_W-1:0]   tnew;
      logic               back;

      assign en_i   = bus.en[i];
      assign init_i = bus.init[i];
      assign th     = bus.time_high[i*CNT_W +: CNT_W];
      assign tl     = bus.time_low[i*CNT_W +: CNT_W];
      assign blen   = bus.burst_len[i*BURST_W +: BURST_W];

      // State and output registers; outputs are all registered copies.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            pcnt   <= '0;
            lvl    <= 1'b0;
            outq   <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
         end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            pcnt   <= pcnt_nxt;
            lvl    <= lvl_nxt;
            outq   <= out_nxt;
            err_q  <= err_nxt;
            done_q <= done_nxt;
            busy_q <= (state_nxt != IDLE);
         end
      end

      // Next-state logic. In RUN/STOP the output register doubles as the
      // current phase; lvl is the rest level captured when the run began.
      // A channel that flagged err refuses to restart until en drops.
      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         pcnt_nxt  = pcnt;
         lvl_nxt   = lvl;
         out_nxt   = outq;
         err_nxt   = err_q;
         done_nxt  = 1'b0;
         tstart    = init_i ? th : tl;
         tnew      = outq ? tl : th;
         back      = (outq != lvl);

         case (state)
            IDLE: begin
               out_nxt = init_i;
               if (!en_i) begin
                  err_nxt = 1'b0;
               end else if (!err_q) begin
                  if (tstart == '0) begin
                     err_nxt = 1'b1;
                  end else begin
                     state_nxt = RUN;
                     lvl_nxt   = init_i;
                     cnt_nxt   = tstart - CNT_W'(1);
                     pcnt_nxt  = blen;
                  end
               end
            end

            RUN, STOP: begin
               state_nxt = en_i ? RUN : STOP;
               if (cnt != '0) begin
                  cnt_nxt = cnt - CNT_W'(1);
               end else if (back && (!en_i || pcnt == BURST_W'(1))) begin
                  // Returning to rest level ends a stop or the last burst period.
                  out_nxt  = lvl;
                  cnt_nxt  = '0;
                  done_nxt = (pcnt == BURST_W'(1));
                  if (pcnt != '0) begin
                     pcnt_nxt = pcnt - BURST_W'(1);
                  end
                  state_nxt = en_i ? HOLD : IDLE;
               end else if (tnew == '0) begin
                  err_nxt   = 1'b1;
                  out_nxt   = lvl;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  out_nxt = ~outq;
                  cnt_nxt = tnew - CNT_W'(1);
                  if (back && pcnt != '0) begin
                     pcnt_nxt = pcnt - BURST_W'(1);
                  end
               end
            end

            HOLD: begin
               out_nxt = lvl;
               if (!en_i) begin
                  state_nxt = IDLE;
               end
            end

            default: begin
               state_nxt = IDLE;
            end
         endcase
      end

      assign clocks_v[i] = outq;
      assign busy_v[i]   = busy_q;
      assign done_v[i]   = done_q;
      assign err_v[i]    = err_q;
   end

   assign bus.clocks = clocks_v;
   assign bus.busy   = busy_v;
   assign bus.done   = done_v;
   assign bus.err    = err_v;

endmodule

// File: tb/tb_tenv_clkgen_div.sv
// Directed bench for tenv_clkgen_div: phase timing, stop, burst, zero-length
// error, mid-phase reprogramming and asynchronous reset.
module tb_tenv_clkgen_div;

   logic clk;
   logic rst_n;
   int   testsRun;
   int   testsFailed;
   int   riseCnt;
   logic prevClk0;
   logic [10:0] pat;

   tenv_clkgen_div_if #(.CHANNELS(2), .CNT_W(16), .BURST_W(8)) bus ();

   tenv_clkgen_div #(.CHANNELS(2), .CNT_W(16), .BURST_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one master cycle; inputs change and outputs are sampled 1ns after the edge.
   task automatic applyStimulus(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (bus.clocks[0] && !prevClk0) riseCnt++;
         prevClk0 = bus.clocks[0];
      end
   endtask

   initial begin
      testsRun      = 0;
      testsFailed   = 0;
      riseCnt       = 0;
      prevClk0      = 1'b0;
      rst_n         = 1'b0;
      bus.init      = 2'b10;
      bus.en        = 2'b00;
      bus.time_high = {16'd2, 16'd2};
      bus.time_low  = {16'd3, 16'd3};
      bus.burst_len = 16'd0;

      // Reset state, then init tracking with one cycle of lag.
      applyStimulus(2);
      checkOutput("rst_clocks", 32'(bus.clocks), 32'h0);
      checkOutput("rst_busy",   32'(bus.busy),   32'h0);
      checkOutput("rst_done",   32'(bus.done),   32'h0);
      checkOutput("rst_err",    32'(bus.err),    32'h0);
      rst_n = 1'b1;
      applyStimulus(1);
      checkOutput("idle_track_init", 32'(bus.clocks), 32'h2);
      bus.init = 2'b00;
      applyStimulus(1);
      checkOutput("idle_track_zero", 32'(bus.clocks), 32'h0);

      // Free run high=2 low=3 init=0: 0 for 3 cycles, then 1,1,0,0,0.
      bus.en[0] = 1'b1;
      pat = 11'b01100011000;
      for (int k = 0; k <= 10; k++) begin
         applyStimulus(1);
         checkOutput($sformatf("run_pattern_%0d", k), 32'(bus.clocks[0]), 32'(pat[k]));
         if (k == 0) checkOutput("busy_after_start", 32'(bus.busy[0]), 32'h1);
      end

      // Drop en during the high phase: high completes, then rests at 0.
      applyStimulus(3);
      checkOutput("stop_hi_pre", 32'(bus.clocks[0]), 32'h1);
      bus.en[0] = 1'b0;
      applyStimulus(1);
      checkOutput("stop_hi_full", 32'(bus.clocks[0]), 32'h1);
      applyStimulus(1);
      checkOutput("stop_hi_end", 32'(bus.clocks[0]), 32'h0);
      applyStimulus(4);
      checkOutput("stop_hi_idle_clk",  32'(bus.clocks[0]), 32'h0);
      checkOutput("stop_hi_idle_busy", 32'(bus.busy[0]),   32'h0);

      // Drop en during the initial low stretch: one full high phase follows.
      bus.en[0] = 1'b1;
      applyStimulus(2);
      bus.en[0] = 1'b0;
      applyStimulus(2);
      checkOutput("stop_lo_rise", 32'(bus.clocks[0]), 32'h1);
      checkOutput("stop_lo_busy", 32'(bus.busy[0]),   32'h1);
      applyStimulus(1);
      checkOutput("stop_lo_high2", 32'(bus.clocks[0]), 32'h1);
      applyStimulus(1);
      checkOutput("stop_lo_end",  32'(bus.clocks[0]), 32'h0);
      checkOutput("stop_lo_idle", 32'(bus.busy[0]),   32'h0);

      // Burst of 3 periods with en held high.
      bus.burst_len[7:0] = 8'd3;
      bus.en[0] = 1'b1;
      riseCnt = 0;
      applyStimulus(15);
      checkOutput("burst_last_high", 32'(bus.clocks[0]), 32'h1);
      checkOutput("burst_no_early_done", 32'(bus.done[0]), 32'h0);
      applyStimulus(1);
      checkOutput("burst_done_pulse", 32'(bus.done[0]),   32'h1);
      checkOutput("burst_end_level",  32'(bus.clocks[0]), 32'h0);
      applyStimulus(1);
      checkOutput("burst_done_1cyc",  32'(bus.done[0]),   32'h0);
      applyStimulus(10);
      checkOutput("burst_hold_busy",  32'(bus.busy[0]),   32'h1);
      checkOutput("burst_hold_clk",   32'(bus.clocks[0]), 32'h0);
      checkOutput("burst_periods",    32'(riseCnt),       32'd3);
      bus.en[0] = 1'b0;
      applyStimulus(1);
      checkOutput("burst_release", 32'(bus.busy[0]), 32'h0);
      bus.burst_len[7:0] = 8'd0;

      // Zero high length at the first phase change.
      bus.time_high[15:0] = 16'd0;
      bus.en[0] = 1'b1;
      applyStimulus(3);
      checkOutput("zero_pre_err", 32'(bus.err[0]), 32'h0);
      applyStimulus(1);
      checkOutput("zero_err",  32'(bus.err[0]),    32'h1);
      checkOutput("zero_busy", 32'(bus.busy[0]),   32'h0);
      checkOutput("zero_clk",  32'(bus.clocks[0]), 32'h0);
      applyStimulus(3);
      checkOutput("zero_sticky", 32'(bus.err[0]),  32'h1);
      checkOutput("zero_no_restart", 32'(bus.busy[0]), 32'h0);
      bus.en[0] = 1'b0;
      applyStimulus(1);
      checkOutput("zero_clear", 32'(bus.err[0]), 32'h0);
      bus.time_high[15:0] = 16'd2;

      // Lengthen time_low mid-low: current low stays 3, next low is 6.
      bus.en[0] = 1'b1;
      applyStimulus(7);
      bus.time_low[15:0] = 16'd6;
      applyStimulus(1);
      checkOutput("tl_cur_low", 32'(bus.clocks[0]), 32'h0);
      applyStimulus(1);
      checkOutput("tl_cur_end", 32'(bus.clocks[0]), 32'h1);
      applyStimulus(2);
      checkOutput("tl_next_low_start", 32'(bus.clocks[0]), 32'h0);
      applyStimulus(5);
      checkOutput("tl_next_low_late", 32'(bus.clocks[0]), 32'h0);
      applyStimulus(1);
      checkOutput("tl_next_low_end", 32'(bus.clocks[0]), 32'h1);

      // Asynchronous reset with both channels running.
      bus.init[1] = 1'b1;
      bus.en      = 2'b11;
      applyStimulus(3);
      checkOutput("both_busy", 32'(bus.busy), 32'h3);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_clocks", 32'(bus.clocks), 32'h0);
      checkOutput("async_busy",   32'(bus.busy),   32'h0);
      checkOutput("async_done",   32'(bus.done),   32'h0);
      bus.en = 2'b00;
      applyStimulus(2);
      rst_n = 1'b1;
      checkOutput("release_clocks", 32'(bus.clocks), 32'h0);
      applyStimulus(1);
      checkOutput("release_track", 32'(bus.clocks), 32'h2);
      checkOutput("release_busy",  32'(bus.busy),   32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
